// File: rtl/rpm_led_gauge.sv
// rtl/rpm_led_gauge.sv - RPM bar-graph gauge with staged status LED, over-rev pulse and peak hold
module rpm_led_gauge #(
  parameter int BAR_WIDTH  = 5,
  parameter int LEVEL_W    = 4,
  parameter int HOLD_CYC   = 200,
  parameter int BLINK_HALF = 250,
  parameter int PEAK_HOLD  = 500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LEVEL_W-1:0]   speed_level,
  input  logic [LEVEL_W-1:0]   max_level,
  output logic [1:0]           stage,
  output logic [2:0]           rgb,
  output logic [BAR_WIDTH-1:0] bar,
  output logic                 overrev
);

  // Wide enough that speed*BAR_WIDTH and k*max_level never wrap.
  localparam int CW  = LEVEL_W + 5;
  localparam int FW  = $clog2(BAR_WIDTH + 1);
  localparam int DW  = $clog2(HOLD_CYC + 1);
  localparam int BKW = $clog2(BLINK_HALF + 1);
  localparam int PW  = $clog2(PEAK_HOLD + 1);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_CAUTION = 2'd1,
    ST_DANGER  = 2'd2
  } stage_e;

  stage_e               stage_q, stage_d, target;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [BKW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                 blink_on_q, blink_on_d;
  logic                 overrev_q, overrev_d;
  logic [FW-1:0]        peak_q, peak_d, peak_dec, fill;
  logic [PW-1:0]        hold_q, hold_d;
  logic [BAR_WIDTH-1:0] live, marker, bar_q, bar_d;
  logic [CW-1:0]        spd_scaled;

  assign spd_scaled = CW'(speed_level) * CW'(BAR_WIDTH);

  // Live segments: segment 0 shows any motion, segment k shows speed >= k/BAR_WIDTH of redline.
  always_comb begin
    live = '0;
    fill = '0;
    if (max_level != '0) begin
      live[0] = (speed_level != '0);
      for (int k = 1; k < BAR_WIDTH; k++) begin
        live[k] = (spd_scaled >= CW'(k) * CW'(max_level));
      end
    end
    for (int k = 0; k < BAR_WIDTH; k++) begin
      fill = fill + FW'(live[k]);
    end
  end

  // Instantaneous stage the inputs ask for, before hysteresis.
  always_comb begin
    target = ST_NORMAL;
    if (max_level == '0) begin
      target = ST_NORMAL;
    end else if (speed_level >= max_level) begin
      target = ST_DANGER;
    end else if (speed_level >= (max_level >> 1)) begin
      target = ST_CAUTION;
    end
  end

  // Stage FSM next state: immediate upgrade, dwell-qualified downgrade, blink and over-rev bookkeeping.
  always_comb begin
    stage_d     = stage_q;
    dwell_d     = '0;
    blink_cnt_d = '0;
    blink_on_d  = blink_on_q;
    if (target > stage_q) begin
      stage_d = target;
    end else if (target < stage_q) begin
      if (dwell_q == DW'(HOLD_CYC - 1)) begin
        stage_d = target;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
    overrev_d = (stage_d == ST_DANGER) && (stage_q != ST_DANGER);
    if (overrev_d) begin
      blink_on_d = 1'b1;
    end else if (stage_d == ST_DANGER) begin
      if (blink_cnt_q == BKW'(BLINK_HALF - 1)) begin
        blink_on_d = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Peak tracker: jump up instantly, decay one segment per hold period but never below fill.
  always_comb begin
    peak_dec = (peak_q != '0) ? peak_q - 1'b1 : '0;
    peak_d   = peak_q;
    hold_d   = hold_q + 1'b1;
    if (fill > peak_q) begin
      peak_d = fill;
      hold_d = '0;
    end else if (hold_q == PW'(PEAK_HOLD - 1)) begin
      peak_d = (peak_dec > fill) ? peak_dec : fill;
      hold_d = '0;
    end
    marker = (peak_d != '0) ? (BAR_WIDTH'(1) << (peak_d - 1'b1)) : '0;
    bar_d  = live | marker;
  end

  // State registers; reset abandons any dwell, blink or hold in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q     <= ST_NORMAL;
      dwell_q     <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      overrev_q   <= 1'b0;
      peak_q      <= '0;
      hold_q      <= '0;
      bar_q       <= '0;
    end else begin
      stage_q     <= stage_d;
      dwell_q     <= dwell_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      overrev_q   <= overrev_d;
      peak_q      <= peak_d;
      hold_q      <= hold_d;
      bar_q       <= bar_d;
    end
  end

  // Status LED colour from the current stage and blink phase.
  always_comb begin
    rgb = 3'b010;
    case (stage_q)
      ST_NORMAL:  rgb = 3'b010;
      ST_CAUTION: rgb = 3'b110;
      ST_DANGER:  rgb = blink_on_q ? 3'b100 : 3'b000;
      default:    rgb = 3'b010;
    endcase
  end

  assign stage   = stage_q;
  assign bar     = bar_q;
  assign overrev = overrev_q;

endmodule

// File: doc/rpm_led_gauge.md
RPM_LED_GAUGE -- requirements
Module: rpm_led_gauge

Interface
REQ-001 Parameter BAR_WIDTH, default 5, number of bar-graph segments (legal 2..16).
REQ-002 Parameter LEVEL_W, default 4, width of speed_level and max_level.
REQ-003 Parameter HOLD_CYC, default 200, consecutive cycles a lower stage target must persist before the stage downgrades.
REQ-004 Parameter BLINK_HALF, default 250, cycles per half-period of the DANGER red blink.
REQ-005 Parameter PEAK_HOLD, default 500, cycles the peak marker holds before each one-segment decay step.
REQ-006 Port list:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- speed_level  input  LEVEL_W  current RPM level.
- max_level  input  LEVEL_W  redline level for the selected gear.
- stage  output  2  0=NORMAL, 1=CAUTION, 2=DANGER; value 3 never driven.
- rgb  output  3  {R,G,B} status LED.
- bar  output  BAR_WIDTH  bar graph with the peak marker ORed in.
- overrev  output  1  one-cycle pulse on each entry to DANGER.

Function
REQ-007 fill (0..BAR_WIDTH) SHALL be the count of lit live segments; live segment 0 lit iff speed_level>0; live segment k (k>=1) lit iff speed_level*BAR_WIDTH >= k*max_level.
REQ-008 Comparisons SHALL use width LEVEL_W+5 unsigned with no truncation.
REQ-009 If max_level==0, all live segments SHALL be 0 (fill=0).
REQ-010 bar SHALL be registered: live segments | (peak>0 ? bit peak-1 : 0), updated one cycle after inputs change.
REQ-011 target stage is the first match:
- max_level==0 -> NORMAL.
- speed_level>=max_level -> DANGER.
- speed_level >= (max_level>>1) -> CAUTION.
- otherwise NORMAL.
REQ-012 Stage FSM states SHALL be NORMAL, CAUTION, DANGER.
REQ-013 Upgrade: if target>stage, stage SHALL take target on the next clock edge; jumps such as NORMAL->DANGER are direct.
REQ-014 Downgrade: if target<stage for HOLD_CYC consecutive cycles, stage SHALL take the current target on that cycle's edge; DANGER->NORMAL may occur directly.
REQ-015 The dwell counter SHALL clear whenever target>=stage and on every stage change.
REQ-016 rgb SHALL be combinational from stage and blink phase:
- NORMAL -> 3'b010.
- CAUTION -> 3'b110.
- DANGER -> 3'b100 when blink phase is on, 3'b000 when off.
REQ-017 On entry to DANGER, the blink phase SHALL be set to on and its counter cleared; the phase toggles every BLINK_HALF cycles while in DANGER.
REQ-018 The blink counter SHALL be held at 0 outside DANGER.
REQ-019 overrev SHALL be 1 for exactly the first cycle stage reads DANGER after any other stage; it is not reasserted while DANGER is held.
REQ-020 Peak register peak (0..BAR_WIDTH) and hold counter:
- If fill>peak: peak<=fill and the counter reloads.
- Else, on counter expiry after PEAK_HOLD cycles: peak<=max(peak-1, fill) and the counter reloads.
- peak SHALL never be below fill one cycle after fill settles.
REQ-021 If fill==peak, the hold counter SHALL keep running; decay then clamps at fill, so peak is unchanged.

Reset
REQ-022 While rst=1, regardless of clk: stage=NORMAL, rgb=3'b010, bar=0, overrev=0, peak=0, and all counters=0.
REQ-023 Reset asserted mid-dwell, mid-blink or mid-hold SHALL abandon that operation.
REQ-024 After rst deasserts, the first clock edge SHALL evaluate inputs normally.

Verification
REQ-025 Defaults, max=10, speed 0->5 -> next cycle: bar=5'b00111, stage=CAUTION, rgb=110, overrev=0.
REQ-026 max=10, speed 0->10 -> next cycle: stage=DANGER, overrev pulses 1 cycle, rgb=100 for 250 cycles, then 000 for 250 cycles, repeating.
REQ-027 From DANGER, speed->2 -> stage holds DANGER for 199 cycles and becomes NORMAL on cycle 200; a speed bump to 10 at cycle 150 restarts the dwell.
REQ-028 max=10, speed 10->0 -> live bar=0 next cycle; peak marker steps 5,4,3,2,1,0 at 500-cycle intervals (bar=10000, 01000, ...).
REQ-029 max=0, any speed -> bar=0, stage=NORMAL; rst pulsed while in DANGER -> outputs immediately at reset values without a clock edge.
REQ-030 BAR_WIDTH=8, LEVEL_W=6, max=63, speed=63 -> bar=8'hFF, fill=8, no overflow.
